// File: rtl/jump_target_unit_if.sv
// jump_target_unit_if: request/result bus between decode and the next-PC stage.
interface jump_target_unit_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 26,
  parameter int IMM_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] pc;
  logic [IDX_W-1:0]  idx;
  logic [IMM_W-1:0]  imm;
  logic [ADDR_W-1:0] rs_val;
  logic              rs_is_ra;
  logic              taken;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] link;
  logic              link_we;
  logic              misalign;
  logic              bad_mode;
  logic              ras_hit;
  modport master (
    output in_valid, mode, pc, idx, imm, rs_val, rs_is_ra, taken, out_ready,
    input  in_ready, out_valid, target, link, link_we, misalign, bad_mode, ras_hit
  );
  modport slave (
    input  in_valid, mode, pc, idx, imm, rs_val, rs_is_ra, taken, out_ready,
    output in_ready, out_valid, target, link, link_we, misalign, bad_mode, ras_hit
  );
endinterface

// File: rtl/jump_target_unit.sv
// jump_target_unit: registered next-PC/link stage for J, JAL, JR, JALR and branches.
// Define JTU_RAS_EN to build the return-address stack that cross-checks JR $ra.
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 26,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  jump_target_unit_if.slave bus
);
  localparam logic [2:0] M_J = 3'd0, M_JAL = 3'd1, M_JR = 3'd2, M_JALR = 3'd3, M_BR = 3'd4;
  if (ADDR_W < IDX_W + 3 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_cfg_err
    $error("jump_target_unit: illegal parameter set");
  end
  logic              acc, is_j, is_jal, is_jr, is_jalr, is_br, is_rsv, hit_nx;
  logic [ADDR_W-1:0] pc4, j_tgt, imm_sx, b_off, tgt_nx;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;
  always_comb begin
    is_j    = bus.mode == M_J;
    is_jal  = bus.mode == M_JAL;
    is_jr   = bus.mode == M_JR;
    is_jalr = bus.mode == M_JALR;
    is_br   = bus.mode == M_BR;
    is_rsv  = bus.mode > M_BR;
    pc4     = bus.pc + ADDR_W'(4);
    j_tgt   = {bus.pc[ADDR_W-1:IDX_W+2], bus.idx, 2'b00};
    imm_sx  = ADDR_W'(signed'(bus.imm));
    b_off   = {imm_sx[ADDR_W-3:0], 2'b00};
    tgt_nx  = (is_j || is_jal)     ? j_tgt :
              (is_jr || is_jalr)   ? bus.rs_val :
              (is_br && bus.taken) ? pc4 + b_off : pc4;
  end
`ifdef JTU_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]     ptr, ptr_dn;
  logic [PW:0]       cnt;
  logic              push, pop;
  assign push   = acc && (is_jal || is_jalr);
  assign ptr_dn = ptr - PW'(1);
  assign pop    = acc && is_jr && bus.rs_is_ra && cnt != '0;
  assign hit_nx = pop && ras[ptr_dn] == bus.rs_val;
  // Circular buffer: pushing past a full stack overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else if (push) begin
      ras[ptr] <= pc4;
      ptr      <= ptr + PW'(1);
      cnt      <= (cnt == (PW+1)'(RAS_DEPTH)) ? cnt : cnt + (PW+1)'(1);
    end else if (pop) begin
      ptr <= ptr_dn;
      cnt <= cnt - (PW+1)'(1);
    end
  end
`else
  assign hit_nx = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.target    <= '0;
      bus.link      <= '0;
      bus.link_we   <= 1'b0;
      bus.misalign  <= 1'b0;
      bus.bad_mode  <= 1'b0;
      bus.ras_hit   <= 1'b0;
    end else if (acc) begin
      bus.out_valid <= 1'b1;
      bus.target    <= tgt_nx;
      bus.link      <= pc4;
      bus.link_we   <= is_jal || is_jalr;
      bus.misalign  <= (is_jr || is_jalr) && |bus.rs_val[1:0];
      bus.bad_mode  <= is_rsv;
      bus.ras_hit   <= hit_nx;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_jump_target_unit.sv
// tb_jump_target_unit: random and directed checks against a queue-based reference model.
module tb_jump_target_unit;
  localparam int AW = 32, IW = 26, MW = 16, DEPTH = 4;
`ifdef JTU_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  jump_target_unit_if #(.ADDR_W(AW), .IDX_W(IW), .IMM_W(MW)) bus ();
  jump_target_unit #(.ADDR_W(AW), .IDX_W(IW), .IMM_W(MW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0, failures = 0;
  logic        m_valid, m_we, m_mis, m_bad, m_hit;
  logic [31:0] m_target, m_link;
  logic [31:0] ras_q[$];
  logic [31:0] links[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_valid = 0; m_we = 0; m_mis = 0; m_bad = 0; m_hit = 0;
    m_target = 0; m_link = 0;
    ras_q.delete();
  endtask
  task automatic model_accept();
    logic [31:0] pc4;
    pc4 = bus.pc + 32'd4;
    case (bus.mode)
      3'd0, 3'd1: m_target = (bus.pc & 32'hF000_0000) | (32'(bus.idx) * 4);
      3'd2, 3'd3: m_target = bus.rs_val;
      3'd4:       m_target = bus.taken ? pc4 + 32'(int'($signed(bus.imm)) * 4) : pc4;
      default:    m_target = pc4;
    endcase
    m_link  = pc4;
    m_we    = bus.mode == 3'd1 || bus.mode == 3'd3;
    m_mis   = (bus.mode == 3'd2 || bus.mode == 3'd3) && (bus.rs_val % 4 != 0);
    m_bad   = bus.mode > 3'd4;
    m_hit   = 0;
    m_valid = 1;
    if (m_we) links.push_back(pc4);
    if (RAS) begin
      if (m_we) begin
        ras_q.push_back(pc4);
        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end else if (bus.mode == 3'd2 && bus.rs_is_ra && ras_q.size() > 0) begin
        m_hit = ras_q.pop_back() == bus.rs_val;
      end
    end
  endtask
  task automatic compare();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check("target", bus.target, m_target);
      check("link", bus.link, m_link);
      check("link_we", 32'(bus.link_we), 32'(m_we));
      check("misalign", 32'(bus.misalign), 32'(m_mis));
      check("bad_mode", 32'(bus.bad_mode), 32'(m_bad));
      check("ras_hit", 32'(bus.ras_hit), 32'(m_hit));
    end
  endtask
  // Called just after a falling edge: drive, predict the accept, clock once, compare.
  task automatic cycle(input logic [2:0] md, input logic [31:0] pc, input logic [25:0] idx,
                       input logic [15:0] imm, input logic [31:0] rs, input logic ra,
                       input logic tk, input logic iv, input logic ordy);
    logic exp_ready;
    bus.mode = md; bus.pc = pc; bus.idx = idx; bus.imm = imm; bus.rs_val = rs;
    bus.rs_is_ra = ra; bus.taken = tk; bus.in_valid = iv; bus.out_ready = ordy;
    #1;
    exp_ready = !m_valid || ordy;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    if (iv && exp_ready) model_accept();
    else if (ordy) m_valid = 0;
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [2:0]  md;
    logic [31:0] rs;
    bus.in_valid = 0; bus.out_ready = 1; bus.mode = 0; bus.pc = 0; bus.idx = 0;
    bus.imm = 0; bus.rs_val = 0; bus.rs_is_ra = 0; bus.taken = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_target", bus.target, 32'd0);
    check("reset_link", bus.link, 32'd0);
    check("reset_link_we", 32'(bus.link_we), 32'd0);
    check("reset_ras_hit", 32'(bus.ras_hit), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(3'd0, 32'h8000_1000, 26'h40, 16'h0, 32'h0, 0, 0, 1, 1);
    check("j_target_lit", bus.target, 32'h8000_0100);
    check("j_link_we_lit", 32'(bus.link_we), 32'd0);
    cycle(3'd1, 32'h0040_0010, 26'h010_0000, 16'h0, 32'h0, 0, 0, 1, 1);
    check("jal_target_lit", bus.target, 32'h0040_0000);
    check("jal_link_lit", bus.link, 32'h0040_0014);
    check("jal_link_we_lit", 32'(bus.link_we), 32'd1);
    cycle(3'd2, 32'h0040_0100, 26'h0, 16'h0, 32'h0040_0014, 1, 0, 1, 1);
    check("jr_target_lit", bus.target, 32'h0040_0014);
    check("jr_ras_hit_lit", 32'(bus.ras_hit), 32'(RAS));
    cycle(3'd4, 32'h0000_0100, 26'h0, 16'hFFFF, 32'h0, 0, 1, 1, 1);
    check("br_taken_lit", bus.target, 32'h0000_0100);
    cycle(3'd4, 32'h0000_0100, 26'h0, 16'hFFFF, 32'h0, 0, 0, 1, 1);
    check("br_not_taken_lit", bus.target, 32'h0000_0104);
    cycle(3'd4, 32'hFFFF_FFFC, 26'h0, 16'h0010, 32'h0, 0, 0, 1, 1);
    check("br_wrap_lit", bus.target, 32'h0000_0000);
    cycle(3'd2, 32'h0000_2000, 26'h0, 16'h0, 32'h0000_0102, 0, 0, 1, 1);
    check("jr_misalign_lit", 32'(bus.misalign), 32'd1);
    check("jr_mis_target_lit", bus.target, 32'h0000_0102);
    cycle(3'd6, 32'h0000_1000, 26'h0, 16'h0, 32'h0, 0, 0, 1, 1);
    check("rsv_bad_mode_lit", 32'(bus.bad_mode), 32'd1);
    check("rsv_target_lit", bus.target, 32'h0000_1004);
    check("rsv_link_we_lit", 32'(bus.link_we), 32'd0);
    cycle(3'd0, 32'h8000_0000, 26'h1, 16'h0, 32'h0, 0, 0, 0, 1);
    cycle(3'd0, 32'h1000_0000, 26'h5, 16'h0, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(3'd4, 32'h0000_3000 + 32'(i), 26'h0, 16'h8, 32'h0, 0, 1, 1, 0);
      check("stall_in_ready_lit", 32'(bus.in_ready), 32'd0);
      check("stall_target_lit", bus.target, 32'h1000_0014);
    end
    cycle(3'd4, 32'h0000_3000, 26'h0, 16'h8, 32'h0, 0, 1, 1, 1);
    check("stall_release_lit", bus.target, 32'h0000_3024);
    for (int k = 1; k <= 5; k++)
      cycle(3'd1, 32'(k) * 32'h1000, 26'h0, 16'h0, 32'h0, 0, 0, 1, 1);
    for (int k = 5; k >= 1; k--) begin
      cycle(3'd2, 32'h0000_9000, 26'h0, 16'h0, 32'(k) * 32'h1000 + 32'd4, 1, 0, 1, 1);
      if (k >= 2) check("pop_hit_lit", 32'(bus.ras_hit), 32'(RAS));
    end
    check("pop_empty_lit", 32'(bus.ras_hit), 32'd0);
    cycle(3'd1, 32'h0000_7000, 26'h0, 16'h0, 32'h0, 0, 0, 1, 1);
    cycle(3'd2, 32'h0000_9000, 26'h0, 16'h0, 32'h0000_7004, 1, 0, 1, 1);
    check("pop_after_empty_lit", 32'(bus.ras_hit), 32'(RAS));
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(3'd1, 32'h0000_5000, 26'h0, 16'h0, 32'h0, 0, 0, 1, 0);
        async_reset();
      end
      md = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      rs = $urandom;
      if (links.size() > 0 && $urandom_range(0, 2) != 0)
        rs = links[$urandom_range(0, links.size() - 1)];
      cycle(md, $urandom, 26'($urandom), 16'($urandom), rs, $urandom_range(0, 3) != 0,
            1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (links.size() > 16) void'(links.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
